// File: rtl/packed_lane_accumulator.sv
// packed_lane_accumulator: per-lane saturating frame accumulator over packed input words.
module packed_lane_accumulator #(
  parameter int LANES  = 2,
  parameter int LANE_W = 4,
  parameter int ACC_W  = 8,
  parameter int SIGNED = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*LANE_W-1:0]  in_data,
  input  logic [7:0]               len,
  input  logic                     clear,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*ACC_W-1:0]   out_data,
  output logic [LANES-1:0]         out_sat
);
  if (ACC_W < LANE_W + 1) begin : g_bad_acc_w
    $error("ACC_W must be at least LANE_W+1");
  end
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
  state_t                         r_state;
  logic [0:LANES-1][ACC_W-1:0]    r_acc;
  logic [0:LANES-1]               r_sat;
  logic [7:0]                     r_cnt, r_len;
  logic [0:LANES-1][LANE_W-1:0]   w_lane;
  logic [0:LANES-1][ACC_W-1:0]    w_ext, w_add;
  logic [0:LANES-1][ACC_W:0]      w_wide;
  logic [0:LANES-1]               w_ovf;
  logic [7:0]                     w_cnt_nx;
  assign w_lane   = in_data;
  assign w_cnt_nx = r_cnt + 8'd1;
  // one guard bit per lane exposes overflow; clamp direction comes from the guard bit
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      w_ext[k]  = {{(ACC_W-LANE_W){SIGNED != 0 && w_lane[k][LANE_W-1]}}, w_lane[k]};
      w_wide[k] = {SIGNED != 0 && w_ext[k][ACC_W-1], w_ext[k]} + {SIGNED != 0 && r_acc[k][ACC_W-1], r_acc[k]};
      w_ovf[k]  = (SIGNED != 0) ? (w_wide[k][ACC_W] != w_wide[k][ACC_W-1]) : w_wide[k][ACC_W];
      w_add[k]  = !w_ovf[k] ? w_wide[k][ACC_W-1:0] :
                  ((SIGNED != 0 && w_wide[k][ACC_W]) ? {1'b1, {(ACC_W-1){1'b0}}} : {SIGNED == 0, {(ACC_W-1){1'b1}}});
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_sat   <= '0;
      r_cnt   <= '0;
      r_len   <= '0;
    end else if (clear) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_sat   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_acc   <= w_ext;
          r_sat   <= '0;
          r_cnt   <= 8'd1;
          r_len   <= (len == 8'd0) ? 8'd1 : len;
          r_state <= (len <= 8'd1) ? DONE : ACC;
        end
        ACC: if (in_valid) begin
          r_acc   <= w_add;
          r_sat   <= r_sat | w_ovf;
          r_cnt   <= w_cnt_nx;
          r_state <= (w_cnt_nx == r_len) ? DONE : ACC;
        end
        DONE: if (out_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
  assign in_ready  = r_state != DONE;
  assign out_valid = r_state == DONE;
  assign out_data  = r_acc;
  assign out_sat   = r_sat;
endmodule

// File: tb/tb_packed_lane_accumulator.sv
// tb_packed_lane_accumulator: signed and unsigned instances share stimulus; checked against an integer model.
module tb_packed_lane_accumulator;
  logic clk = 0, rst_n = 0, in_valid = 0, clear = 0, out_ready = 0;
  logic [7:0] in_data = 0, len = 0;
  logic s_ir, s_ov, u_ir, u_ov;
  logic [15:0] s_od, u_od;
  logic [1:0] s_os, u_os;
  logic [36:0] obs, exp_v;
  logic [7:0] mem [0:255];
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  assign obs = {s_ov, s_od, s_os, u_od, u_os};
  packed_lane_accumulator #(.LANES(2), .LANE_W(4), .ACC_W(8), .SIGNED(1)) u_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_ir), .in_data(in_data), .len(len),
    .clear(clear), .out_valid(s_ov), .out_ready(out_ready), .out_data(s_od), .out_sat(s_os));
  packed_lane_accumulator #(.LANES(2), .LANE_W(4), .ACC_W(8), .SIGNED(0)) u_u (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(u_ir), .in_data(in_data), .len(len),
    .clear(clear), .out_valid(u_ov), .out_ready(out_ready), .out_data(u_od), .out_sat(u_os));

  // {out_data, out_sat} for a frame of n beats taken from mem, via integer sums with clamping
  function automatic logic [17:0] model(input bit sg, input int n);
    logic [15:0] d;
    logic [1:0] st;
    logic [3:0] v;
    int acc, x, lo, hi;
    bit sat;
    d = '0;
    st = '0;
    lo = sg ? -128 : 0;
    hi = sg ? 127 : 255;
    for (int i = 0; i < 2; i++) begin
      acc = 0;
      sat = 0;
      for (int k = 0; k < n; k++) begin
        v = mem[k][7-4*i -: 4];
        x = int'(v);
        if (sg && x > 7) x -= 16;
        acc = (k == 0) ? x : acc + x;
        if (acc > hi) begin acc = hi; sat = 1; end
        else if (acc < lo) begin acc = lo; sat = 1; end
      end
      d[15-8*i -: 8] = acc[7:0];
      st[1-i] = sat;
    end
    return {d, st};
  endfunction

  task automatic send(input logic [7:0] l, input int n);
    for (int k = 0; k < n; k++) begin
      in_valid = 1;
      in_data = mem[k];
      len = l;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 0;
  endtask

  task automatic drain();
    out_ready = 1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 0;
  endtask

  task automatic test_reset();
    #12;
    total++;
    if ({s_ir, u_ir, s_ov, u_ov, s_od, u_od, s_os, u_os} !== {1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 4'h0}) begin
      bad++;
      $display("FAIL reset: got ir=%b%b ov=%b%b od=%h/%h sat=%b/%b want ir=11 ov=00 od=0 sat=0",
               s_ir, u_ir, s_ov, u_ov, s_od, u_od, s_os, u_os);
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_single();
    mem[0] = 8'hC8;
    send(8'd1, 1);
    total++;
    if (obs !== {1'b1, 16'hFCF8, 2'b00, 16'h0C08, 2'b00}) begin
      bad++;
      $display("FAIL single_c8: got %h want %h", obs, {1'b1, 16'hFCF8, 2'b00, 16'h0C08, 2'b00});
    end
    total++;
    if ({s_ir, u_ir} !== 2'b00) begin
      bad++;
      $display("FAIL done_in_ready: got %b want 00", {s_ir, u_ir});
    end
    drain();
  endtask

  task automatic test_len0();
    mem[0] = 8'h5A;
    send(8'd0, 1);
    exp_v = {1'b1, model(1, 1), model(0, 1)};
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL len0: got %h want %h", obs, exp_v);
    end
    drain();
  endtask

  task automatic test_saturate();
    for (int k = 0; k < 40; k++) mem[k] = 8'h78;
    send(8'd40, 40);
    total++;
    if (obs !== {1'b1, 16'h7F80, 2'b11, 16'hFFFF, 2'b11}) begin
      bad++;
      $display("FAIL saturate: got %h want %h", obs, {1'b1, 16'h7F80, 2'b11, 16'hFFFF, 2'b11});
    end
    drain();
  endtask

  task automatic test_backpressure();
    mem[0] = 8'h9E;
    mem[1] = 8'h4B;
    send(8'd2, 2);
    exp_v = {1'b1, model(1, 2), model(0, 2)};
    in_valid = 1;
    in_data = 8'h77;
    for (int c = 0; c < 5; c++) begin
      total++;
      if ({obs, s_ir, u_ir} !== {exp_v, 2'b00}) begin
        bad++;
        $display("FAIL hold_%0d: got %h ir=%b%b want %h ir=00", c, obs, s_ir, u_ir, exp_v);
      end
      @(posedge clk);
      @(negedge clk);
    end
    drain();
    in_valid = 0;
    total++;
    if ({s_ov, u_ov, s_ir, u_ir, s_od, s_os, u_od, u_os} !== {4'b0011, exp_v[35:0]}) begin
      bad++;
      $display("FAIL release: got ov=%b%b ir=%b%b data=%h want ov=00 ir=11 data=%h",
               s_ov, u_ov, s_ir, u_ir, obs[35:0], exp_v[35:0]);
    end
  endtask

  task automatic test_clear();
    for (int k = 0; k < 3; k++) mem[k] = 8'h11;
    send(8'd5, 3);
    clear = 1;
    in_valid = 1;
    in_data = 8'h77;
    @(posedge clk);
    @(negedge clk);
    clear = 0;
    in_valid = 0;
    total++;
    if ({obs, u_ov} !== 38'h0) begin
      bad++;
      $display("FAIL clear_zero: got %h ov_u=%b want 0", obs, u_ov);
    end
    mem[0] = 8'h23;
    send(8'd1, 1);
    total++;
    if (obs !== {1'b1, 16'h0203, 2'b00, 16'h0203, 2'b00}) begin
      bad++;
      $display("FAIL after_clear: got %h want %h", obs, {1'b1, 16'h0203, 2'b00, 16'h0203, 2'b00});
    end
    drain();
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 3; k++) mem[k] = 8'h35;
    send(8'd10, 3);
    #2 rst_n = 0;
    #1;
    total++;
    if ({obs, u_ov, s_ir, u_ir} !== {38'h0, 2'b11}) begin
      bad++;
      $display("FAIL async_reset: got %h ov_u=%b ir=%b%b want 0 ir=11", obs, u_ov, s_ir, u_ir);
    end
    @(negedge clk);
    rst_n = 1;
    mem[0] = 8'($urandom);
    send(8'd1, 1);
    exp_v = {1'b1, model(1, 1), model(0, 1)};
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL post_reset_frame: got %h want %h", obs, exp_v);
    end
    drain();
  endtask

  task automatic test_random();
    int n, w;
    for (int f = 0; f < 20; f++) begin
      n = $urandom_range(1, 12);
      for (int k = 0; k < n; k++) mem[k] = 8'($urandom);
      send(8'(n), n);
      exp_v = {1'b1, model(1, n), model(0, n)};
      w = $urandom_range(0, 3);
      for (int c = 0; c <= w; c++) begin
        total++;
        if (obs !== exp_v) begin
          bad++;
          $display("FAIL rand_f%0d_c%0d len=%0d: got %h want %h", f, c, n, obs, exp_v);
        end
        if (c < w) begin
          @(posedge clk);
          @(negedge clk);
        end
      end
      drain();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_len0();
    test_saturate();
    test_backpressure();
    test_clear();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
